// File: rtl/product_display_driver.sv
// Registers an 8-bit product, converts it to 3-digit BCD with a sequential
// double-dabble, and scans it onto a 4-digit active-low 7-segment display.
// Optional build macro: LEADING_ZERO_BLANK_EN (blanks leading zero digits).
module product_display_driver #(
  parameter int REFRESH_DIV = 100000,
  parameter int PROD_W      = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              prod_valid,
  input  logic [PROD_W-1:0] prod,
  output logic              busy,
  output logic              bcd_valid,
  output logic [11:0]       bcd,
  output logic [3:0]        an,
  output logic [6:0]        seg,
  output logic              dp
);

  localparam int SH_W  = 12 + PROD_W;
  localparam int CNT_W = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CNT_W-1:0] REFRESH_MAX = CNT_W'(REFRESH_DIV - 1);

  typedef enum logic [1:0] {S_IDLE, S_CONV, S_DONE} state_t;

  state_t          r_state;
  logic [SH_W-1:0] r_shift;
  logic [2:0]      r_count;
  logic            r_busy;
  logic            r_bcd_valid;
  logic [11:0]     r_bcd;
  logic [SH_W-1:0] w_adj;

  logic [CNT_W-1:0] r_refresh;
  logic [1:0]       r_digit;
  logic [3:0]       r_an;
  logic [6:0]       r_seg;
  logic [1:0]       w_next_digit;
  logic [3:0]       w_nib;
  logic             w_blank;
  logic [6:0]       w_seg_next;

  // Add-3 correction on each BCD nibble ahead of the shift.
  assign w_adj[PROD_W-1:0] = r_shift[PROD_W-1:0];
  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_adj
      assign w_adj[PROD_W+4*gi +: 4] = (r_shift[PROD_W+4*gi +: 4] >= 4'd5) ?
                                       r_shift[PROD_W+4*gi +: 4] + 4'd3 :
                                       r_shift[PROD_W+4*gi +: 4];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_shift     <= '0;
      r_count     <= '0;
      r_busy      <= 1'b0;
      r_bcd_valid <= 1'b0;
      r_bcd       <= 12'h000;
    end else begin
      r_bcd_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (prod_valid) begin
            r_shift <= {12'h000, prod};
            r_count <= '0;
            r_busy  <= 1'b1;
            r_state <= S_CONV;
          end
        end
        S_CONV: begin
          r_shift <= {w_adj[SH_W-2:0], 1'b0};
          r_count <= r_count + 3'd1;
          if (r_count == 3'd7) r_state <= S_DONE;
        end
        S_DONE: begin
          r_bcd       <= r_shift[SH_W-1:PROD_W];
          r_bcd_valid <= 1'b1;
          r_busy      <= 1'b0;
          r_state     <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Select and decode the digit that becomes active at the next scan step.
  assign w_next_digit = r_digit + 2'd1;

  always_comb begin
    w_nib   = 4'd0;
    w_blank = 1'b0;
    case (w_next_digit)
      2'd0: w_nib = r_bcd[3:0];
      2'd1: begin
        w_nib = r_bcd[7:4];
`ifdef LEADING_ZERO_BLANK_EN
        w_blank = (r_bcd[11:8] == 4'd0) && (r_bcd[7:4] == 4'd0);
`endif
      end
      2'd2: begin
        w_nib = r_bcd[11:8];
`ifdef LEADING_ZERO_BLANK_EN
        w_blank = (r_bcd[11:8] == 4'd0);
`endif
      end
      default: w_blank = 1'b1;
    endcase
  end

  always_comb begin
    w_seg_next = 7'h7F;
    if (!w_blank) begin
      case (w_nib)
        4'd0:    w_seg_next = 7'h40;
        4'd1:    w_seg_next = 7'h79;
        4'd2:    w_seg_next = 7'h24;
        4'd3:    w_seg_next = 7'h30;
        4'd4:    w_seg_next = 7'h19;
        4'd5:    w_seg_next = 7'h12;
        4'd6:    w_seg_next = 7'h02;
        4'd7:    w_seg_next = 7'h78;
        4'd8:    w_seg_next = 7'h00;
        4'd9:    w_seg_next = 7'h10;
        default: w_seg_next = 7'h7F;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_refresh <= '0;
      r_digit   <= 2'd0;
      r_an      <= 4'b1110;
      r_seg     <= 7'h40;
    end else if (r_refresh == REFRESH_MAX) begin
      r_refresh <= '0;
      r_digit   <= w_next_digit;
      r_an      <= ~(4'b0001 << w_next_digit);
      r_seg     <= w_seg_next;
    end else begin
      r_refresh <= r_refresh + CNT_W'(1);
    end
  end

  assign busy      = r_busy;
  assign bcd_valid = r_bcd_valid;
  assign bcd       = r_bcd;
  assign an        = r_an;
  assign seg       = r_seg;
  assign dp        = 1'b1;

endmodule

// File: tb/tb_product_display_driver.sv
// Directed bench for product_display_driver with a short refresh period.
module tb_product_display_driver;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        prod_valid = 1'b0;
  logic [7:0]  prod = 8'd0;
  logic        busy, bcd_valid, dp;
  logic [11:0] bcd;
  logic [3:0]  an;
  logic [6:0]  seg;

  int total = 0;
  int bad   = 0;
  int vcnt, bcnt;
  logic [6:0] dig_seg [4];
  logic [6:0] lead_exp;

  product_display_driver #(.REFRESH_DIV(4), .PROD_W(8)) dut (
    .clk(clk), .rst(rst), .prod_valid(prod_valid), .prod(prod),
    .busy(busy), .bcd_valid(bcd_valid), .bcd(bcd),
    .an(an), .seg(seg), .dp(dp)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
    $display("check %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Pulse one product, then check busy length, the single valid pulse and bcd.
  task automatic conv(input logic [7:0] p, input logic [11:0] exp);
    prod_valid = 1'b1;
    prod = p;
    tick;
    prod_valid = 1'b0;
    bcnt = busy ? 1 : 0;
    vcnt = 0;
    for (int i = 0; i < 8; i++) begin
      tick;
      bcnt += busy ? 1 : 0;
      vcnt += bcd_valid ? 1 : 0;
    end
    tick;
    chk($sformatf("valid_e9_%0d", p), {31'd0, bcd_valid}, 32'd1);
    chk($sformatf("bcd_%0d", p), {20'd0, bcd}, {20'd0, exp});
    chk($sformatf("busy_len_%0d", p), bcnt, 9);
    chk($sformatf("early_valid_%0d", p), vcnt, 0);
    tick;
    chk($sformatf("valid_drop_%0d", p), {31'd0, bcd_valid}, 32'd0);
  endtask

  // Let every digit refresh, then record seg for each anode over a full scan.
  task automatic grab_digits;
    for (int k = 0; k < 4; k++) dig_seg[k] = 7'h55;
    repeat (16) tick;
    for (int i = 0; i < 16; i++) begin
      case (an)
        4'b1110: dig_seg[0] = seg;
        4'b1101: dig_seg[1] = seg;
        4'b1011: dig_seg[2] = seg;
        4'b0111: dig_seg[3] = seg;
        default: ;
      endcase
      tick;
    end
  endtask

  initial begin
`ifdef LEADING_ZERO_BLANK_EN
    lead_exp = 7'h7F;
`else
    lead_exp = 7'h40;
`endif
    // Reset state
    tick;
    tick;
    chk("rst_bcd", {20'd0, bcd}, 32'h000);
    chk("rst_an", {28'd0, an}, 32'he);
    chk("rst_seg", {25'd0, seg}, 32'h40);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_valid", {31'd0, bcd_valid}, 32'd0);
    chk("rst_dp", {31'd0, dp}, 32'd1);
    rst = 1'b0;

    // Scan order, 4 cycles per digit
    repeat (3) tick;
    chk("scan_hold", {28'd0, an}, 32'he);
    tick;
    chk("scan_an1", {28'd0, an}, 32'hd);
    chk("scan_seg1", {25'd0, seg}, {25'd0, lead_exp});
    repeat (4) tick;
    chk("scan_an2", {28'd0, an}, 32'hb);
    repeat (4) tick;
    chk("scan_an3", {28'd0, an}, 32'h7);
    chk("scan_seg3", {25'd0, seg}, 32'h7f);
    repeat (4) tick;
    chk("scan_an0", {28'd0, an}, 32'he);
    chk("scan_seg0", {25'd0, seg}, 32'h40);

    // 15 x 15 and its display
    conv(8'd225, 12'h225);
    grab_digits;
    chk("d225_0", {25'd0, dig_seg[0]}, 32'h12);
    chk("d225_1", {25'd0, dig_seg[1]}, 32'h24);
    chk("d225_2", {25'd0, dig_seg[2]}, 32'h24);
    chk("d225_3", {25'd0, dig_seg[3]}, 32'h7f);

    conv(8'd0, 12'h000);
    conv(8'd99, 12'h099);
    conv(8'd100, 12'h100);

    // prod_valid during conversion is dropped
    prod_valid = 1'b1;
    prod = 8'd42;
    tick;
    prod_valid = 1'b0;
    tick;
    tick;
    prod_valid = 1'b1;
    prod = 8'd81;
    tick;
    prod_valid = 1'b0;
    vcnt = 0;
    for (int i = 0; i < 15; i++) begin
      tick;
      vcnt += bcd_valid ? 1 : 0;
    end
    chk("drop_pulses", vcnt, 1);
    chk("drop_bcd", {20'd0, bcd}, 32'h042);
    chk("drop_busy", {31'd0, busy}, 32'd0);

    // Back-to-back captures at E0 and E10
    prod_valid = 1'b1;
    prod = 8'd13;
    tick;
    repeat (8) tick;
    tick;
    chk("b2b_bcd1", {20'd0, bcd}, 32'h013);
    chk("b2b_valid1", {31'd0, bcd_valid}, 32'd1);
    prod = 8'd56;
    tick;
    chk("b2b_busy_e10", {31'd0, busy}, 32'd1);
    prod_valid = 1'b0;
    repeat (8) tick;
    tick;
    chk("b2b_bcd2", {20'd0, bcd}, 32'h056);
    chk("b2b_valid2", {31'd0, bcd_valid}, 32'd1);

    // Reset at E5 of converting 200
    prod_valid = 1'b1;
    prod = 8'd200;
    tick;
    prod_valid = 1'b0;
    repeat (4) tick;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    chk("abort_bcd", {20'd0, bcd}, 32'h000);
    chk("abort_busy", {31'd0, busy}, 32'd0);
    vcnt = 0;
    for (int i = 0; i < 12; i++) begin
      tick;
      vcnt += bcd_valid ? 1 : 0;
    end
    chk("abort_no_valid", vcnt, 0);
    conv(8'd7, 12'h007);
    grab_digits;
    chk("d7_0", {25'd0, dig_seg[0]}, 32'h78);
    chk("d7_1", {25'd0, dig_seg[1]}, {25'd0, lead_exp});
    chk("d7_2", {25'd0, dig_seg[2]}, {25'd0, lead_exp});
    chk("d7_3", {25'd0, dig_seg[3]}, 32'h7f);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
